scene_ring_buffer: RTL and testbench
====================================

Name: scene_ring_buffer

Overview:
Parametrised N-slot ring buffer of scene entries between the scene loader (write side) and the rasteriser front-end (read side).
- Generalises scene double-buffering to arbitrary slot count, depth and entry width.
- Adds valid/ready handshakes on both sides, abort of a partially written scene, overflow/truncation tracking and explicit last-entry marking.
- Adds an optional keep-last mode that replays the newest scene until a newer one is committed.

Parameters:
SCENE_COUNT, 2, number of scene slots; ≥2, need not be a power of two.
DEPTH, 50, maximum entries per scene; ≥1.
DATA_W, 128, entry width in bits (packed model instance).
KEEP_LAST, 0, 1 = replay the final ready scene instead of freeing it.

Ports:
clk  in  1  clock
rstn  in  1  reset
wr_valid  in  1  write entry offered
wr_ready  out  1  entry can be accepted
wr_data  in  DATA_W  entry payload
wr_commit  in  1  pulse: close current scene, mark ready
wr_abort  in  1  pulse: discard current partial scene
wr_slot_busy  out  1  current write slot still holds an unread scene
rd_valid  out  1  rd_data valid
rd_ready  in  1  consumer accepts entry
rd_data  out  DATA_W  current entry
rd_last  out  1  rd_data is the final entry of the scene
rd_restart  in  1  pulse: restart current read scene at entry 0
rd_size  out  $clog2(DEPTH+1)  entry count of current read scene
rd_truncated  out  1  current read scene overflowed while being written
scenes_ready  out  $clog2(SCENE_COUNT+1)  number of committed, unreleased scenes

Behaviour:
Reset:
- Reset is asynchronous, active-low (rstn); clock is clk.
- Reset clears all slot ready/truncated flags and sizes, wr/rd slot and entry indices, and scenes_ready.
- Every output is 0 during and after reset, except wr_ready = 1.
- Storage contents are undefined after reset.
- Reset mid-scene drops all scenes with no residual state.

Write side:
- A beat is accepted when wr_valid && wr_ready. wr_ready = !wr_slot_busy && wr_cnt < DEPTH.
- An accepted beat writes mem[wr_slot][wr_cnt] and increments wr_cnt.
- wr_valid with wr_cnt == DEPTH (and slot not busy) drops the beat and sets the slot's sticky truncated flag.
- wr_commit with wr_cnt > 0 (counting a beat accepted in the same cycle) and slot not busy:
  - Sets the slot's ready flag and latches size.
  - Advances wr_slot, wrapping SCENE_COUNT-1 → 0.
  - Clears wr_cnt; scenes_ready increments.
- wr_commit with zero entries is ignored: no slot is consumed, and the truncated flag is cleared.
- wr_commit while wr_slot_busy is ignored.
- wr_abort clears wr_cnt and the truncated flag; the slot stays free.
- wr_abort and wr_commit in the same cycle: abort wins. A beat accepted in that cycle is discarded.

Read side:
- rd_valid = ready flag of rd_slot.
- rd_data = mem[rd_slot][rd_idx], combinational from the indices (zero added latency).
- rd_last = rd_valid && rd_idx == rd_size-1.
- rd_size and rd_truncated reflect rd_slot; they are 0 when !rd_valid.
- A handshake (rd_valid && rd_ready) with !rd_last increments rd_idx.
- A handshake with rd_last releases the slot: clears ready, truncated and size, advances rd_slot with wrap, sets rd_idx = 0, and decrements scenes_ready.
- KEEP_LAST = 1 and scenes_ready == 1 with no commit in the same cycle: rd_last handshake does not release. rd_idx returns to 0 and the scene replays.
  - Once a newer scene is committed, the next rd_last handshake releases the retained slot normally.
- rd_restart sets rd_idx = 0 and overrides any same-cycle increment; a rd_last handshake in that cycle is ignored (no release).

Simultaneous events:
- Commit and release in the same cycle: scenes_ready is unchanged; both slot updates apply.
- A commit into slot k and a release of a different slot are independent.
- wr_slot_busy reflects the state before the current clock edge, so a slot freed on the edge is writable from the next cycle.

Arithmetic:
- All counters are unsigned.
- wr_cnt and rd_size are $clog2(DEPTH+1) bits wide, so DEPTH itself is representable.
- Slot indices are $clog2(SCENE_COUNT) bits wide with an explicit compare-and-wrap.

Test Plan:
1. SCENE_COUNT=3, DEPTH=4: write 3 entries (0xA,0xB,0xC), commit; read with rd_ready=1 → rd_data A,B,C; rd_last on C; scenes_ready 1→0; rd_valid low next cycle.
2. DEPTH=4: offer 6 beats, commit → wr_ready low after beat 4; rd_size=4; rd_truncated=1; beats 5–6 absent.
3. Commit scenes into all 3 slots → wr_slot_busy=1, wr_ready=0, scenes_ready=3. Drain one scene → writer resumes into slot 0 (wrap); the fourth scene reads back after scenes 2 and 3.
4. Write 2 entries, wr_abort, write 1 entry 0x55, commit → read side sees rd_size=1, data 0x55. Separately, wr_commit with 0 entries → scenes_ready stays 0.
5. KEEP_LAST=1, one scene of 2 entries: read 4 beats → sequence e0,e1,e0,e1, slot retained. Commit a new scene mid-replay → current pass completes, then the new scene is read and the old slot is freed.
6. Final-entry handshake coincident with a commit → scenes_ready unchanged. rd_restart at rd_idx=2 → next rd_data is entry 0. Assert rstn mid-write → all outputs zero, wr_ready=1.

Source files
------------

// File: rtl/scene_ring_buffer.sv
// N-slot ring buffer of scene entries between the scene loader (write side)
// and the rasteriser front-end (read side), with valid/ready on both sides.
module scene_ring_buffer #(
   parameter int SCENE_COUNT = 2,
   parameter int DEPTH       = 50,
   parameter int DATA_W      = 128,
   parameter int KEEP_LAST   = 0
) (
   input  logic                               clk,
   input  logic                               rstn,
   input  logic                               wr_valid,
   output logic                               wr_ready,
   input  logic [DATA_W-1:0]                  wr_data,
   input  logic                               wr_commit,
   input  logic                               wr_abort,
   output logic                               wr_slot_busy,
   output logic                               rd_valid,
   input  logic                               rd_ready,
   output logic [DATA_W-1:0]                  rd_data,
   output logic                               rd_last,
   input  logic                               rd_restart,
   output logic [$clog2(DEPTH+1)-1:0]         rd_size,
   output logic                               rd_truncated,
   output logic [$clog2(SCENE_COUNT+1)-1:0]   scenes_ready
);

   localparam int CW = $clog2(DEPTH+1);
   localparam int SW = $clog2(SCENE_COUNT);
   localparam int RW = $clog2(SCENE_COUNT+1);
   localparam int AW = $clog2(SCENE_COUNT*DEPTH);
   localparam logic [SW-1:0] LAST_SLOT = SW'(SCENE_COUNT-1);
   localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);

   // Flat storage: slot-major, so slot s entry e lives at s*DEPTH+e.
   logic [DATA_W-1:0]       mem [SCENE_COUNT*DEPTH];

   logic [SCENE_COUNT-1:0]  slot_ready;
   logic [SCENE_COUNT-1:0]  slot_trunc;
   logic [CW-1:0]           slot_size [SCENE_COUNT];
   logic [SW-1:0]           wr_slot;
   logic [SW-1:0]           rd_slot;
   logic [CW-1:0]           wr_cnt;
   logic [CW-1:0]           rd_idx;
   logic [RW-1:0]           ready_cnt;

   logic                    wr_accept;
   logic                    wr_drop;
   logic [CW-1:0]           wr_cnt_inc;
   logic                    commit_req;
   logic                    commit_ok;
   logic                    commit_empty;
   logic [SW-1:0]           wr_slot_nxt;
   logic [SW-1:0]           rd_slot_nxt;
   logic                    rd_hs;
   logic                    retain;
   logic                    rd_release;
   logic [AW-1:0]           wr_addr;
   logic [AW-1:0]           rd_addr;

   assign wr_slot_busy = slot_ready[wr_slot];
   assign wr_ready     = !wr_slot_busy && (wr_cnt < DEPTH_C);
   assign wr_accept    = wr_valid && wr_ready;
   assign wr_drop      = wr_valid && !wr_slot_busy && (wr_cnt == DEPTH_C);
   assign wr_cnt_inc   = wr_cnt + CW'(wr_accept);

   // Abort outranks commit; a commit only consumes a slot if it carries data.
   assign commit_req   = wr_commit && !wr_abort && !wr_slot_busy;
   assign commit_ok    = commit_req && (wr_cnt_inc != '0);
   assign commit_empty = commit_req && (wr_cnt_inc == '0);

   assign wr_slot_nxt  = (wr_slot == LAST_SLOT) ? '0 : wr_slot + 1'b1;
   assign rd_slot_nxt  = (rd_slot == LAST_SLOT) ? '0 : rd_slot + 1'b1;

   assign rd_valid     = slot_ready[rd_slot];
   assign rd_size      = rd_valid ? slot_size[rd_slot] : '0;
   assign rd_truncated = rd_valid && slot_trunc[rd_slot];
   assign rd_last      = rd_valid && (rd_idx == rd_size - CW'(1));
   assign rd_hs        = rd_valid && rd_ready;

   // Keep-last holds the only ready scene unless a newer one lands this cycle.
   assign retain       = (KEEP_LAST != 0) && (ready_cnt == RW'(1)) && !commit_ok;
   assign rd_release   = rd_hs && rd_last && !rd_restart && !retain;

   assign wr_addr      = AW'(wr_slot) * AW'(DEPTH) + AW'(wr_cnt);
   assign rd_addr      = AW'(rd_slot) * AW'(DEPTH) + AW'(rd_idx);
   assign rd_data      = rd_valid ? mem[rd_addr] : '0;
   assign scenes_ready = ready_cnt;

   always_ff @(posedge clk) begin
      if (wr_accept) begin
         mem[wr_addr] <= wr_data;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         slot_ready <= '0;
         slot_trunc <= '0;
         for (int i = 0; i < SCENE_COUNT; i++) begin
            slot_size[i] <= '0;
         end
         wr_slot   <= '0;
         rd_slot   <= '0;
         wr_cnt    <= '0;
         rd_idx    <= '0;
         ready_cnt <= '0;
      end else begin
         if (wr_abort) begin
            wr_cnt <= '0;
            if (!wr_slot_busy) begin
               slot_trunc[wr_slot] <= 1'b0;
            end
         end else if (commit_ok) begin
            if (wr_drop) begin
               slot_trunc[wr_slot] <= 1'b1;
            end
            slot_ready[wr_slot] <= 1'b1;
            slot_size[wr_slot]  <= wr_cnt_inc;
            wr_slot             <= wr_slot_nxt;
            wr_cnt              <= '0;
         end else begin
            if (commit_empty) begin
               slot_trunc[wr_slot] <= 1'b0;
            end else if (wr_drop) begin
               slot_trunc[wr_slot] <= 1'b1;
            end
            wr_cnt <= wr_cnt_inc;
         end

         if (rd_restart) begin
            rd_idx <= '0;
         end else if (rd_hs && rd_last) begin
            rd_idx <= '0;
         end else if (rd_hs) begin
            rd_idx <= rd_idx + 1'b1;
         end

         // The released slot is always ready and the committed one never is,
         // so these per-slot updates cannot collide.
         if (rd_release) begin
            slot_ready[rd_slot] <= 1'b0;
            slot_trunc[rd_slot] <= 1'b0;
            slot_size[rd_slot]  <= '0;
            rd_slot             <= rd_slot_nxt;
         end

         case ({commit_ok, rd_release})
            2'b10:   ready_cnt <= ready_cnt + 1'b1;
            2'b01:   ready_cnt <= ready_cnt - 1'b1;
            default: ready_cnt <= ready_cnt;
         endcase
      end
   end

endmodule

// File: tb/tb_scene_ring_buffer.sv
// Directed bench for scene_ring_buffer: a vector table for basic write/read and
// truncation, plus hand sequences for wrap, abort, keep-last, restart and reset.
module tb_scene_ring_buffer;

   localparam int SC  = 3;
   localparam int DEP = 4;
   localparam int DW  = 16;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   logic          a_wv, a_wc, a_wa, a_rr, a_rs;
   logic [DW-1:0] a_wd;
   logic          a_wrdy, a_busy, a_rv, a_rl, a_rt;
   logic [DW-1:0] a_rd;
   logic [2:0]    a_sz;
   logic [1:0]    a_sr;

   logic          b_wv, b_wc, b_wa, b_rr, b_rs;
   logic [DW-1:0] b_wd;
   logic          b_wrdy, b_busy, b_rv, b_rl, b_rt;
   logic [DW-1:0] b_rd;
   logic [2:0]    b_sz;
   logic [1:0]    b_sr;

   scene_ring_buffer #(.SCENE_COUNT(SC), .DEPTH(DEP), .DATA_W(DW), .KEEP_LAST(0)) dut_a (
      .clk(clk), .rstn(rstn),
      .wr_valid(a_wv), .wr_ready(a_wrdy), .wr_data(a_wd), .wr_commit(a_wc),
      .wr_abort(a_wa), .wr_slot_busy(a_busy),
      .rd_valid(a_rv), .rd_ready(a_rr), .rd_data(a_rd), .rd_last(a_rl),
      .rd_restart(a_rs), .rd_size(a_sz), .rd_truncated(a_rt), .scenes_ready(a_sr)
   );

   scene_ring_buffer #(.SCENE_COUNT(SC), .DEPTH(DEP), .DATA_W(DW), .KEEP_LAST(1)) dut_b (
      .clk(clk), .rstn(rstn),
      .wr_valid(b_wv), .wr_ready(b_wrdy), .wr_data(b_wd), .wr_commit(b_wc),
      .wr_abort(b_wa), .wr_slot_busy(b_busy),
      .rd_valid(b_rv), .rd_ready(b_rr), .rd_data(b_rd), .rd_last(b_rl),
      .rd_restart(b_rs), .rd_size(b_sz), .rd_truncated(b_rt), .scenes_ready(b_sr)
   );

   typedef struct {
      logic          wv;
      logic [DW-1:0] wd;
      logic          wc, wa, rr, rs;
      logic          wrdy, busy, rv;
      logic [DW-1:0] rd;
      logic          rl;
      logic [2:0]    sz;
      logic          rt;
      logic [1:0]    sr;
   } vec_t;

   vec_t tbl[$];
   int checks = 0;
   int failures = 0;

   function automatic vec_t mk(logic wv, logic [DW-1:0] wd, logic wc, logic wa, logic rr,
                               logic rs, logic wrdy, logic busy, logic rv, logic [DW-1:0] rd,
                               logic rl, logic [2:0] sz, logic rt, logic [1:0] sr);
      vec_t v;
      v.wv = wv; v.wd = wd; v.wc = wc; v.wa = wa; v.rr = rr; v.rs = rs;
      v.wrdy = wrdy; v.busy = busy; v.rv = rv; v.rd = rd; v.rl = rl;
      v.sz = sz; v.rt = rt; v.sr = sr;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic a_idle();
      a_wv = 0; a_wd = '0; a_wc = 0; a_wa = 0; a_rr = 0; a_rs = 0;
   endtask

   task automatic b_idle();
      b_wv = 0; b_wd = '0; b_wc = 0; b_wa = 0; b_rr = 0; b_rs = 0;
   endtask

   task automatic a_write(input logic [DW-1:0] d);
      a_wv = 1; a_wd = d; step(); a_wv = 0;
   endtask

   task automatic a_commit();
      a_wc = 1; step(); a_wc = 0;
   endtask

   task automatic b_write(input logic [DW-1:0] d);
      b_wv = 1; b_wd = d; step(); b_wv = 0;
   endtask

   task automatic b_commit();
      b_wc = 1; step(); b_wc = 0;
   endtask

   task automatic a_read(input string nm, input logic [DW-1:0] d, input logic l,
                         input logic [2:0] sz);
      chk({nm, ".rd_valid"}, a_rv, 1);
      chk({nm, ".rd_data"}, a_rd, d);
      chk({nm, ".rd_last"}, a_rl, l);
      chk({nm, ".rd_size"}, a_sz, sz);
      a_rr = 1; step(); a_rr = 0;
   endtask

   task automatic b_read(input string nm, input logic [DW-1:0] d, input logic l);
      chk({nm, ".rd_valid"}, b_rv, 1);
      chk({nm, ".rd_data"}, b_rd, d);
      chk({nm, ".rd_last"}, b_rl, l);
      b_rr = 1; step(); b_rr = 0;
   endtask

   task automatic a_zero(input string nm);
      chk({nm, ".wr_ready"}, a_wrdy, 1);
      chk({nm, ".wr_slot_busy"}, a_busy, 0);
      chk({nm, ".rd_valid"}, a_rv, 0);
      chk({nm, ".rd_data"}, a_rd, 0);
      chk({nm, ".rd_last"}, a_rl, 0);
      chk({nm, ".rd_size"}, a_sz, 0);
      chk({nm, ".rd_truncated"}, a_rt, 0);
      chk({nm, ".scenes_ready"}, a_sr, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog timeout checks=%0d", checks);
      $fatal(1);
   end

   initial begin
      vec_t v;
      a_idle();
      b_idle();
      rstn = 0;
      #12;
      a_zero("rst_in");
      chk("rst_in.b_wr_ready", b_wrdy, 1);
      chk("rst_in.b_scenes_ready", b_sr, 0);
      rstn = 1;
      step();

      // wv wd wc wa rr rs | wrdy busy rv rd rl sz rt sr
      tbl.push_back(mk(1, 16'h000A, 0, 0, 0, 0, 1, 0, 0, 16'h0000, 0, 0, 0, 0));
      tbl.push_back(mk(1, 16'h000B, 0, 0, 0, 0, 1, 0, 0, 16'h0000, 0, 0, 0, 0));
      tbl.push_back(mk(1, 16'h000C, 1, 0, 0, 0, 1, 0, 0, 16'h0000, 0, 0, 0, 0));
      tbl.push_back(mk(0, 16'h0000, 0, 0, 1, 0, 1, 0, 1, 16'h000A, 0, 3, 0, 1));
      tbl.push_back(mk(0, 16'h0000, 0, 0, 1, 0, 1, 0, 1, 16'h000B, 0, 3, 0, 1));
      tbl.push_back(mk(0, 16'h0000, 0, 0, 1, 0, 1, 0, 1, 16'h000C, 1, 3, 0, 1));
      tbl.push_back(mk(0, 16'h0000, 0, 0, 0, 0, 1, 0, 0, 16'h0000, 0, 0, 0, 0));
      tbl.push_back(mk(1, 16'h0010, 0, 0, 0, 0, 1, 0, 0, 16'h0000, 0, 0, 0, 0));
      tbl.push_back(mk(1, 16'h0011, 0, 0, 0, 0, 1, 0, 0, 16'h0000, 0, 0, 0, 0));
      tbl.push_back(mk(1, 16'h0012, 0, 0, 0, 0, 1, 0, 0, 16'h0000, 0, 0, 0, 0));
      tbl.push_back(mk(1, 16'h0013, 0, 0, 0, 0, 1, 0, 0, 16'h0000, 0, 0, 0, 0));
      tbl.push_back(mk(1, 16'h0014, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 0));
      tbl.push_back(mk(1, 16'h0015, 1, 0, 0, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 0));
      tbl.push_back(mk(0, 16'h0000, 0, 0, 1, 0, 1, 0, 1, 16'h0010, 0, 4, 1, 1));
      tbl.push_back(mk(0, 16'h0000, 0, 0, 1, 0, 1, 0, 1, 16'h0011, 0, 4, 1, 1));
      tbl.push_back(mk(0, 16'h0000, 0, 0, 1, 0, 1, 0, 1, 16'h0012, 0, 4, 1, 1));
      tbl.push_back(mk(0, 16'h0000, 0, 0, 1, 0, 1, 0, 1, 16'h0013, 1, 4, 1, 1));
      tbl.push_back(mk(0, 16'h0000, 0, 0, 0, 0, 1, 0, 0, 16'h0000, 0, 0, 0, 0));

      for (int i = 0; i < tbl.size(); i++) begin
         v = tbl[i];
         chk($sformatf("v%0d.wr_ready", i), a_wrdy, v.wrdy);
         chk($sformatf("v%0d.wr_slot_busy", i), a_busy, v.busy);
         chk($sformatf("v%0d.rd_valid", i), a_rv, v.rv);
         chk($sformatf("v%0d.rd_data", i), a_rd, v.rd);
         chk($sformatf("v%0d.rd_last", i), a_rl, v.rl);
         chk($sformatf("v%0d.rd_size", i), a_sz, v.sz);
         chk($sformatf("v%0d.rd_truncated", i), a_rt, v.rt);
         chk($sformatf("v%0d.scenes_ready", i), a_sr, v.sr);
         a_wv = v.wv; a_wd = v.wd; a_wc = v.wc; a_wa = v.wa; a_rr = v.rr; a_rs = v.rs;
         step();
      end
      a_idle();

      // fill all slots from a fresh reset, then wrap the writer
      rstn = 0;
      step();
      a_zero("rst2");
      rstn = 1;
      step();
      for (int i = 0; i < SC; i++) begin
         a_write(16'h0021 + 16'(i));
         a_commit();
      end
      chk("full.scenes_ready", a_sr, 3);
      chk("full.wr_slot_busy", a_busy, 1);
      chk("full.wr_ready", a_wrdy, 0);
      a_wv = 1; a_wd = 16'h0099; a_wc = 1; step(); a_idle();
      chk("busy_commit.scenes_ready", a_sr, 3);
      a_read("drain0", 16'h0021, 1, 1);
      chk("freed.wr_slot_busy", a_busy, 0);
      chk("freed.wr_ready", a_wrdy, 1);
      chk("freed.scenes_ready", a_sr, 2);
      a_write(16'h0024);
      a_commit();
      chk("wrap.scenes_ready", a_sr, 3);
      chk("wrap.wr_slot_busy", a_busy, 1);
      a_read("wrap_s2", 16'h0022, 1, 1);
      a_read("wrap_s3", 16'h0023, 1, 1);
      a_read("wrap_s4", 16'h0024, 1, 1);
      chk("wrap_end.rd_valid", a_rv, 0);
      chk("wrap_end.scenes_ready", a_sr, 0);

      // abort of a partial scene
      a_write(16'h0041);
      a_write(16'h0042);
      a_wa = 1; step(); a_wa = 0;
      a_write(16'h0055);
      a_commit();
      a_read("abort", 16'h0055, 1, 1);

      // abort clears a pending truncation
      for (int i = 0; i < DEP; i++) a_write(16'h0070 + 16'(i));
      chk("trunc_fill.wr_ready", a_wrdy, 0);
      a_write(16'h0074);
      a_wa = 1; step(); a_wa = 0;
      chk("trunc_abort.wr_ready", a_wrdy, 1);
      a_write(16'h0077);
      a_commit();
      chk("trunc_abort.rd_truncated", a_rt, 0);
      a_read("trunc_abort", 16'h0077, 1, 1);

      // empty commit, then abort+commit with a beat in the same cycle
      a_commit();
      chk("empty_commit.scenes_ready", a_sr, 0);
      chk("empty_commit.rd_valid", a_rv, 0);
      a_write(16'h0081);
      a_wv = 1; a_wd = 16'h0082; a_wc = 1; a_wa = 1; step(); a_idle();
      chk("abort_commit.scenes_ready", a_sr, 0);
      a_write(16'h0083);
      a_commit();
      a_read("abort_commit", 16'h0083, 1, 1);

      // final handshake coincident with a commit
      a_write(16'h0061);
      a_write(16'h0062);
      a_commit();
      a_read("coinc_e0", 16'h0061, 0, 2);
      chk("coinc.rd_last", a_rl, 1);
      a_rr = 1; a_wv = 1; a_wd = 16'h0063; a_wc = 1; step(); a_idle();
      chk("coinc.scenes_ready", a_sr, 1);
      a_read("coinc_next", 16'h0063, 1, 1);
      chk("coinc_end.scenes_ready", a_sr, 0);

      // restart mid-scene and on the last entry
      for (int i = 0; i < DEP; i++) a_write(16'h0030 + 16'(i));
      a_commit();
      a_read("rst_e0", 16'h0030, 0, 4);
      a_read("rst_e1", 16'h0031, 0, 4);
      chk("restart_at2.rd_data", a_rd, 16'h0032);
      a_rr = 1; a_rs = 1; step(); a_idle();
      chk("restart.rd_data", a_rd, 16'h0030);
      for (int i = 0; i < DEP-1; i++) a_read("rst_pass", 16'h0030 + 16'(i), 0, 4);
      chk("restart_last.rd_last", a_rl, 1);
      a_rr = 1; a_rs = 1; step(); a_idle();
      chk("restart_last.rd_valid", a_rv, 1);
      chk("restart_last.scenes_ready", a_sr, 1);
      chk("restart_last.rd_data", a_rd, 16'h0030);
      for (int i = 0; i < DEP; i++)
         a_read("rst_final", 16'h0030 + 16'(i), (i == DEP-1) ? 1'b1 : 1'b0, 4);
      chk("restart_end.scenes_ready", a_sr, 0);

      // keep-last replay on the second instance
      b_write(16'h0050);
      b_write(16'h0051);
      b_commit();
      for (int i = 0; i < 4; i++)
         b_read($sformatf("keep%0d", i), 16'h0050 + 16'(i % 2), (i % 2 == 1) ? 1'b1 : 1'b0);
      chk("keep.scenes_ready", b_sr, 1);
      chk("keep_mid.rd_data", b_rd, 16'h0050);
      b_rr = 1; b_wv = 1; b_wd = 16'h0060; b_wc = 1; step(); b_idle();
      chk("keep_mid.scenes_ready", b_sr, 2);
      b_read("keep_tail", 16'h0051, 1);
      chk("keep_new.scenes_ready", b_sr, 1);
      chk("keep_new.rd_size", b_sz, 1);
      b_read("keep_new", 16'h0060, 1);
      chk("keep_new_retained.rd_valid", b_rv, 1);
      chk("keep_new_retained.rd_data", b_rd, 16'h0060);
      chk("keep_new_retained.scenes_ready", b_sr, 1);
      b_write(16'h0070);
      b_commit();
      chk("keep_freed.wr_slot_busy", b_busy, 0);
      chk("keep_freed.scenes_ready", b_sr, 2);

      // reset mid-write with a committed scene pending
      a_write(16'h0088);
      a_commit();
      a_wv = 1; a_wd = 16'h0090; step();
      a_wd = 16'h0091; step();
      #2 rstn = 0;
      #1;
      a_zero("rst_mid");
      chk("rst_mid.b_scenes_ready", b_sr, 0);
      a_idle();
      step();
      rstn = 1;
      step();
      a_zero("rst_after");
      a_write(16'h0092);
      a_commit();
      a_read("rst_after", 16'h0092, 1, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
